encoder_period_to_speed: RTL and testbench



---
 rtl/drive_pkg.sv | 20 ++
 rtl/edge_sync_detect.sv | 30 +++
 rtl/encoder_period_to_speed.sv | 161 ++++++++++++++++
 tb/tb_encoder_period_to_speed.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/drive_pkg.sv
// Shared definitions for the wheel-speed path: FSM encoding, default tuning
// constants and a saturating-increment helper.
package drive_pkg;

   typedef logic [1:0] fsm_state_t;

   localparam fsm_state_t ST_IDLE    = 2'd0;
   localparam fsm_state_t ST_LAUNCH  = 2'd1;
   localparam fsm_state_t ST_DIVIDE  = 2'd2;
   localparam fsm_state_t ST_CAPTURE = 2'd3;

   localparam logic [31:0] DEF_SPEED_SCALE  = 32'd50_000_000;
   localparam logic [31:0] DEF_STALL_CYCLES = 32'd25_000_000;
   localparam logic [7:0]  DEF_DIV_TIMEOUT  = 8'd64;

   function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] limit);
      return (value >= limit) ? limit : value + 32'd1;
   endfunction

endpackage

// File: rtl/edge_sync_detect.sv
// Two-flop synchronizer for an asynchronous encoder channel followed by a
// single-cycle rising-edge pulse.
module edge_sync_detect
   import drive_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic async_i,
   output logic rise_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/encoder_period_to_speed.sv
// Measures encoder edge period in clock cycles and sequences an external
// serial divider to publish speed = SPEED_SCALE / period.
module encoder_period_to_speed
   import drive_pkg::*;
#(
   parameter logic [31:0] SPEED_SCALE  = DEF_SPEED_SCALE,
   parameter logic [31:0] STALL_CYCLES = DEF_STALL_CYCLES,
   parameter logic [7:0]  DIV_TIMEOUT  = DEF_DIV_TIMEOUT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enc_a,
   output logic        div_reset,
   output logic        div_start,
   output logic [31:0] div_dividend,
   output logic [31:0] div_divisor,
   input  logic [31:0] div_quotient,
   input  logic        div_done,
   output logic [31:0] speed,
   output logic        speed_valid,
   output logic        stalled,
   output logic        overrun,
   output logic        div_error
);

   logic        enc_rise;

   fsm_state_t  state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic        armed_q, armed_d;
   logic        pending_q, pending_d;
   logic [31:0] hold_q, hold_d;
   logic [7:0]  wait_q, wait_d;
   logic [31:0] divisor_q, divisor_d;
   logic [31:0] speed_q, speed_d;
   logic        valid_q, valid_d;
   logic        stalled_q, stalled_d;
   logic        overrun_q, overrun_d;
   logic        error_q, error_d;

   logic        consume;
   logic        stall_evt;

   edge_sync_detect u_edge (
      .clk     (clk),
      .reset   (reset),
      .async_i (enc_a),
      .rise_o  (enc_rise)
   );

   always_comb begin
      cnt_d     = enc_rise ? 32'd1 : sat_inc(cnt_q, STALL_CYCLES);
      consume   = (state_q == ST_IDLE) && pending_q;
      stall_evt = armed_q && (cnt_q == STALL_CYCLES);

      state_d   = state_q;
      armed_d   = armed_q;
      pending_d = pending_q;
      hold_d    = hold_q;
      wait_d    = wait_q;
      divisor_d = divisor_q;
      speed_d   = speed_q;
      valid_d   = 1'b0;
      stalled_d = stalled_q;
      overrun_d = 1'b0;
      error_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (pending_q) begin
               divisor_d = hold_q;
               pending_d = 1'b0;
               state_d   = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            wait_d  = 8'd0;
            state_d = ST_DIVIDE;
         end
         ST_DIVIDE: begin
            wait_d = wait_q + 8'd1;
            // Quotient is taken on the same edge that first sees done, so the
            // valid pulse lands in the CAPTURE cycle.
            if (div_done) begin
               speed_d   = div_quotient;
               valid_d   = 1'b1;
               stalled_d = 1'b0;
               state_d   = ST_CAPTURE;
            end else if (wait_d == DIV_TIMEOUT) begin
               error_d = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (enc_rise) begin
         if (!armed_q) begin
            armed_d = 1'b1;
         end else if (cnt_q < STALL_CYCLES) begin
            hold_d    = cnt_q;
            pending_d = 1'b1;
            overrun_d = pending_q && !consume;
         end
      end

      // Stall overrides a coincident capture; an edge landing on the stall
      // cycle becomes the new reference edge.
      if (stall_evt) begin
         armed_d   = enc_rise;
         pending_d = 1'b0;
         speed_d   = 32'd0;
         stalled_d = 1'b1;
         valid_d   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 32'd0;
         armed_q   <= 1'b0;
         pending_q <= 1'b0;
         hold_q    <= 32'd0;
         wait_q    <= 8'd0;
         divisor_q <= 32'd0;
         speed_q   <= 32'd0;
         valid_q   <= 1'b0;
         stalled_q <= 1'b1;
         overrun_q <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         armed_q   <= armed_d;
         pending_q <= pending_d;
         hold_q    <= hold_d;
         wait_q    <= wait_d;
         divisor_q <= divisor_d;
         speed_q   <= speed_d;
         valid_q   <= valid_d;
         stalled_q <= stalled_d;
         overrun_q <= overrun_d;
         error_q   <= error_d;
      end
   end

   // div_start is gated by reset so it falls in the cycle reset is applied.
   assign div_reset    = (state_q == ST_LAUNCH);
   assign div_start    = (state_q == ST_DIVIDE) && !reset;
   assign div_dividend = SPEED_SCALE;
   assign div_divisor  = divisor_q;
   assign speed        = speed_q;
   assign speed_valid  = valid_q;
   assign stalled      = stalled_q;
   assign overrun      = overrun_q;
   assign div_error    = error_q;

endmodule

// File: tb/tb_encoder_period_to_speed.sv
// Directed bench for encoder_period_to_speed with a behavioural serial
// divider that raises done 34 div_start cycles after its restart pulse.
module tb_encoder_period_to_speed;

   localparam logic [31:0] SCALE = 32'd1_000_000;
   localparam logic [31:0] STALL = 32'd5000;
   localparam logic [7:0]  TMO   = 8'd64;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enc_a = 1'b0;
   logic        div_reset;
   logic        div_start;
   logic [31:0] div_dividend;
   logic [31:0] div_divisor;
   logic [31:0] div_quotient;
   logic        div_done;
   logic [31:0] speed;
   logic        speed_valid;
   logic        stalled;
   logic        overrun;
   logic        div_error;

   encoder_period_to_speed #(
      .SPEED_SCALE  (SCALE),
      .STALL_CYCLES (STALL),
      .DIV_TIMEOUT  (TMO)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enc_a        (enc_a),
      .div_reset    (div_reset),
      .div_start    (div_start),
      .div_dividend (div_dividend),
      .div_divisor  (div_divisor),
      .div_quotient (div_quotient),
      .div_done     (div_done),
      .speed        (speed),
      .speed_valid  (speed_valid),
      .stalled      (stalled),
      .overrun      (overrun),
      .div_error    (div_error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural divider
   int   dv_cnt = 0;
   logic done_en = 1'b1;
   always @(posedge clk) begin
      if (div_reset)
         dv_cnt <= 0;
      else if (div_start && dv_cnt < 34)
         dv_cnt <= dv_cnt + 1;
   end
   assign div_done     = done_en && (dv_cnt == 34);
   assign div_quotient = (div_divisor != 32'd0) ? div_dividend / div_divisor : 32'hFFFF_FFFF;

   // Event monitor sampled on the falling edge
   int          n_valid = 0, n_ovr = 0, n_err = 0, n_launch = 0, n_glitch = 0;
   int          run = 0, err_run = 0, last_lat = 0, last_rise = 0;
   logic        win = 1'b0;
   logic [31:0] win_div = 32'd0;
   logic [31:0] spd_q[$];

   always @(negedge clk) begin
      if (speed_valid === 1'b1) begin
         n_valid  <= n_valid + 1;
         last_lat <= cyc - last_rise;
         spd_q.push_back(speed);
         $display("[%0d] speed_valid speed=%0d stalled=%0b", cyc, speed, stalled);
      end
      if (overrun === 1'b1) n_ovr <= n_ovr + 1;
      if (div_error === 1'b1) begin
         n_err   <= n_err + 1;
         err_run <= run;
      end
      if (div_reset === 1'b1) begin
         n_launch <= n_launch + 1;
         run      <= 0;
         win      <= 1'b1;
         win_div  <= div_divisor;
      end else begin
         if (div_start === 1'b1) run <= run + 1;
         if (win) begin
            if (div_divisor !== win_div) n_glitch <= n_glitch + 1;
            if (div_start !== 1'b1) win <= 1'b0;
         end
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One encoder rising edge, then wait until the next edge is due
   task automatic edge_gap(input int gap);
      enc_a     = 1'b1;
      last_rise = cyc;
      tick(1);
      enc_a = 1'b0;
      tick(gap - 1);
   endtask

   task automatic pop_speed(input string tag, input logic [31:0] exp);
      logic [31:0] v;
      v = 32'hDEAD_BEEF;
      if (spd_q.size() > 0) v = spd_q.pop_front();
      chk(tag, v, exp);
   endtask

   int base_valid;
   int base_launch;

   initial begin
      // Reset state
      tick(3);
      chk("rst_speed", speed, 32'd0);
      chk("rst_valid", {31'd0, speed_valid}, 32'd0);
      chk("rst_stalled", {31'd0, stalled}, 32'd1);
      chk("rst_overrun", {31'd0, overrun}, 32'd0);
      chk("rst_div_error", {31'd0, div_error}, 32'd0);
      chk("rst_div_reset", {31'd0, div_reset}, 32'd0);
      chk("rst_div_start", {31'd0, div_start}, 32'd0);
      chk("rst_divisor", div_divisor, 32'd0);
      chk("dividend", div_dividend, SCALE);
      reset = 1'b0;
      tick(5);

      // Period 1000: first edge only arms
      edge_gap(1000);
      chk("arm_no_valid", n_valid, 32'd0);
      chk("arm_no_launch", n_launch, 32'd0);
      for (int i = 0; i < 3; i++) begin
         edge_gap(1000);
         pop_speed("p1000_speed", 32'd1000);
         chk("p1000_stalled", {31'd0, stalled}, 32'd0);
         chk("p1000_latency", {31'd0, last_lat <= 70}, 32'd1);
         chk("p1000_divisor", div_divisor, 32'd1000);
      end
      chk("p1000_count", n_valid, 32'd3);

      // Burst at minimum period 2 while the period-1000 division is in flight
      for (int i = 0; i < 4; i++) edge_gap(2);
      tick(300);
      pop_speed("burst_first", 32'd1000);
      pop_speed("burst_min_period", 32'd500_000);
      chk("burst_count", n_valid, 32'd5);
      chk("burst_overrun", n_ovr, 32'd2);
      chk("burst_divisor", div_divisor, 32'd2);

      // Edges stop: stall after STALL cycles
      tick(5000);
      chk("stall_count", n_valid, 32'd6);
      pop_speed("stall_speed_evt", 32'd0);
      chk("stall_speed", speed, 32'd0);
      chk("stall_flag", {31'd0, stalled}, 32'd1);
      chk("stall_timing", last_lat, 32'd5003);

      // After stall: first edge rearms, second gives speed
      base_launch = n_launch;
      edge_gap(1000);
      chk("restall_no_valid", n_valid, 32'd6);
      chk("restall_no_launch", n_launch, base_launch);
      edge_gap(1000);
      pop_speed("restart_speed", 32'd1000);
      chk("restart_stalled", {31'd0, stalled}, 32'd0);

      // Period change 1000 -> 500
      edge_gap(500);
      pop_speed("chg_speed_1000", 32'd1000);
      edge_gap(500);
      pop_speed("chg_speed_2000a", 32'd2000);
      edge_gap(500);
      pop_speed("chg_speed_2000b", 32'd2000);
      chk("chg_divisor", div_divisor, 32'd500);
      chk("divisor_stable", n_glitch, 32'd0);
      chk("chg_count", n_valid, 32'd10);

      // Hung divider: timeout after DIV_TIMEOUT divide cycles
      done_en = 1'b0;
      edge_gap(200);
      chk("tmo_err_count", n_err, 32'd1);
      chk("tmo_run", err_run, {24'd0, TMO});
      chk("tmo_speed", speed, 32'd2000);
      chk("tmo_div_start", {31'd0, div_start}, 32'd0);
      chk("tmo_div_reset", {31'd0, div_reset}, 32'd0);
      chk("tmo_err_pulse", {31'd0, div_error}, 32'd0);
      chk("tmo_no_valid", n_valid, 32'd10);
      done_en = 1'b1;

      // Reset during DIVIDE
      edge_gap(20);
      chk("mid_div_start", {31'd0, div_start}, 32'd1);
      reset = 1'b1;
      tick(1);
      chk("mrst_div_start", {31'd0, div_start}, 32'd0);
      chk("mrst_speed", speed, 32'd0);
      chk("mrst_stalled", {31'd0, stalled}, 32'd1);
      chk("mrst_valid", {31'd0, speed_valid}, 32'd0);
      reset = 1'b0;
      tick(100);
      base_valid  = n_valid;
      base_launch = n_launch;
      chk("mrst_no_valid", base_valid, 32'd10);
      edge_gap(600);
      chk("mrst_arm_no_launch", n_launch, base_launch);
      chk("mrst_arm_no_valid", n_valid, base_valid);
      edge_gap(600);
      pop_speed("mrst_speed_600", 32'd1666);
      chk("mrst_stalled_clr", {31'd0, stalled}, 32'd0);

      chk("final_overrun", n_ovr, 32'd2);
      chk("final_err", n_err, 32'd1);
      chk("final_glitch", n_glitch, 32'd0);
      chk("queue_empty", spd_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
